// File: rtl/modular_reader.sv
// Constant-time consumer: valid/ready input into a small FIFO, words presented downstream
// after a mode-dependent, data-independent latency. in_data only ever reaches out_data.
module modular_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [LW-1:0]    r_cnt;
    logic [LW-1:0]    w_cnt_next;
    logic [LW-1:0]    w_cnt_load;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_out_data;

    logic             w_push;
    logic             w_pop;
    logic             w_fifo_nonempty;
    logic             w_present_hold;

    // Handshake side depends only on registered occupancy, never on in_data or out_ready
    assign in_ready        = (r_count != CW'(DEPTH));
    assign w_fifo_nonempty = (r_count != '0);
    assign w_push          = in_valid && in_ready;
    assign w_cnt_load      = slow ? LW'(LAT - 1) : '0;
    assign out_data        = r_out_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, pop decision and wait-counter update
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_pop          = 1'b0;
        w_present_hold = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_nonempty) begin
                    w_pop        = 1'b1;
                    w_cnt_next   = w_cnt_load;
                    w_state_next = (w_cnt_load != '0) ? S_WAIT : S_PRESENT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - LW'(1);
                if (r_cnt == LW'(1)) begin
                    w_state_next   = S_PRESENT;
                    w_present_hold = 1'b1;
                end
            end
            S_PRESENT: begin
                if (out_ready) begin
                    if (w_fifo_nonempty) begin
                        w_pop        = 1'b1;
                        w_cnt_next   = w_cnt_load;
                        w_state_next = (w_cnt_load != '0) ? S_WAIT : S_PRESENT;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        out_valid = 1'b0;
        if (r_state == S_PRESENT) begin
            out_valid = 1'b1;
        end
    end

    // FIFO storage needs no reset: pointers and count define what is live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy, wait counter and data holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_cnt      <= '0;
            r_hold     <= '0;
            r_out_data <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_hold   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // out_data only changes when a new word becomes visible
            if (w_pop && (w_state_next == S_PRESENT)) begin
                r_out_data <= r_mem[r_rd_ptr];
            end else if (w_present_hold) begin
                r_out_data <= r_hold;
            end
        end
    end

endmodule
